// File: rtl/spart_pkg.sv
// Shared definitions for the SPART transmit and receive halves.
package spart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } spart_state_e;

  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = 10;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/spart_tx_if.sv
// MMU-side write path of the SPART transmitter: strobe, byte and full flag.
interface spart_tx_if;
  import spart_pkg::*;

  logic                 spart_trmt;
  logic [DATA_BITS-1:0] spart_tx_data;
  logic                 spart_tx_full;

  modport master (output spart_trmt, output spart_tx_data, input spart_tx_full);
  modport slave  (input spart_trmt, input spart_tx_data, output spart_tx_full);

endinterface

// File: rtl/spart_fifo.sv
// Small synchronous FIFO; the head entry is visible on dout without a pop
// so a consumer can load it in the same cycle it pops.
module spart_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Accept/pop qualification and pointer/count update; pointers wrap naturally
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  // Storage array, no reset so it can map onto plain RAM
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy registers; reset flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: buffers bytes from the MMU and sends them as 8N1 frames.
module spart_tx
  import spart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_DIV   = 868
) (
  input  logic        clk,
  input  logic        rst,
  spart_tx_if.slave   bus,
  output logic        tx_empty,
  output logic        tx_busy,
  output logic        TxD
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

  spart_state_e         state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;

  logic [DATA_BITS-1:0] fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 has_data;
  logic                 bit_end;
  logic                 pop;

  spart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.spart_trmt),
    .din   (bus.spart_tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign has_data = !fifo_empty;
  assign bit_end  = (baud_q == '0);

  // State and datapath registers; TxD comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  // Next state: each non-idle bit lasts until the baud counter reads zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (has_data) state_d = START;
      START:   if (bit_end) state_d = DATA;
      DATA:    if (bit_end && (bit_idx_q == LAST_BIT)) state_d = STOP;
      STOP:    if (bit_end) state_d = has_data ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pop, baud counter, bit index, shifter and the next line level
  always_comb begin
    pop       = has_data && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    if (state_q == IDLE) begin
      baud_d = pop ? BAUD_LOAD : '0;
    end else if (bit_end) begin
      baud_d = (state_d == IDLE) ? '0 : BAUD_LOAD;
    end else begin
      baud_d = baud_q - 1'b1;
    end

    if ((state_q == START) && bit_end) begin
      bit_idx_d = '0;
    end else if ((state_q == DATA) && bit_end) begin
      bit_idx_d = bit_idx_q + 1'b1;
    end

    if (pop) begin
      shift_d = fifo_dout;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = IDLE_LEVEL;
    endcase
  end

  // Status outputs
  assign bus.spart_tx_full = fifo_full;
  assign tx_busy           = (state_q != IDLE);
  assign tx_empty          = (fifo_count == '0) && (state_q == IDLE);
  assign TxD               = txd_q;

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx with BAUD_DIV=4, FIFO_DEPTH=4.
module tb_spart_tx;

  localparam int BAUD = 4;

  logic clk = 1'b0;
  logic rst;
  logic tx_empty, tx_busy, TxD;

  spart_tx_if bus ();

  spart_tx #(
    .FIFO_DEPTH (4),
    .BAUD_DIV   (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .TxD      (TxD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rec = 1'b0;
  logic       wave_q[$];
  logic [7:0] exp_q[$];

  // Line recorder: one TxD sample per cycle, taken mid-cycle
  always @(negedge clk) begin
    if (rec) wave_q.push_back(TxD);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compares the recorded line against back-to-back frames of exp_q,
  // starting at sample exp_start, followed by an idle-high tail.
  task automatic check_line(input string tag, input int exp_start);
    int f;
    int zeros;
    int idx;
    logic [39:0] obs_w;
    logic [39:0] exp_w;
    logic [9:0]  fr;
    f = -1;
    zeros = 0;
    if (exp_q.size() == 0) begin
      foreach (wave_q[i]) if (wave_q[i] !== 1'b1) zeros++;
      chk({tag, "_quiet"}, zeros, 0);
      return;
    end
    foreach (wave_q[i]) if (f < 0 && wave_q[i] === 1'b0) f = i;
    chk({tag, "_start"}, f, exp_start);
    if (f < 0) f = 0;
    foreach (exp_q[k]) begin
      fr = {1'b1, exp_q[k], 1'b0};
      for (int i = 0; i < 40; i++) begin
        idx = f + 40 * k + i;
        obs_w[i] = (idx < wave_q.size()) ? wave_q[idx] : 1'bx;
        exp_w[i] = fr[i / BAUD];
      end
      chk($sformatf("%s_frm%0d", tag, k), obs_w, exp_w);
    end
    for (int i = f + 40 * exp_q.size(); i < wave_q.size(); i++) begin
      if (wave_q[i] !== 1'b1) zeros++;
    end
    chk({tag, "_tail"}, zeros, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.spart_trmt = 1'b0;
    bus.spart_tx_data = 8'h00;

    // 1. Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_txd", TxD, 1'b1);
      chk("rst_empty", tx_empty, 1'b1);
      chk("rst_full", bus.spart_tx_full, 1'b0);
      chk("rst_busy", tx_busy, 1'b0);
    end
    rst = 1'b0;
    tick();

    // 2. Single byte A5
    wave_q.delete();
    rec = 1'b1;
    bus.spart_trmt = 1'b1;
    bus.spart_tx_data = 8'hA5;
    tick();
    bus.spart_trmt = 1'b0;
    chk("one_txd_n", TxD, 1'b1);
    chk("one_empty_n", tx_empty, 1'b0);
    chk("one_busy_n", tx_busy, 1'b0);
    tick();
    chk("one_txd_n1", TxD, 1'b0);
    chk("one_busy_n1", tx_busy, 1'b1);
    repeat (42) tick();
    rec = 1'b0;
    exp_q = '{8'hA5};
    check_line("single", 2);
    chk("one_empty_end", tx_empty, 1'b1);
    chk("one_busy_end", tx_busy, 1'b0);

    // 3 + 4. Six writes with overflow, then a push colliding with the STOP-end pop
    wave_q.delete();
    rec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.spart_trmt = 1'b1;
      bus.spart_tx_data = 8'(i + 1);
      tick();
      chk($sformatf("ovf_full%0d", i), bus.spart_tx_full, (i >= 4) ? 1'b1 : 1'b0);
    end
    bus.spart_trmt = 1'b0;
    repeat (35) tick();
    chk("col_full_pre", bus.spart_tx_full, 1'b1);
    bus.spart_trmt = 1'b1;
    bus.spart_tx_data = 8'h77;
    tick();
    bus.spart_trmt = 1'b0;
    chk("col_full_post", bus.spart_tx_full, 1'b0);
    bus.spart_trmt = 1'b1;
    bus.spart_tx_data = 8'h88;
    tick();
    bus.spart_trmt = 1'b0;
    chk("col_refill", bus.spart_tx_full, 1'b1);
    repeat (210) tick();
    rec = 1'b0;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h88};
    check_line("burst", 2);
    chk("burst_empty", tx_empty, 1'b1);

    // 5. Reset during DATA bit 3 of FF with two bytes queued
    bus.spart_trmt = 1'b1;
    bus.spart_tx_data = 8'hFF;
    tick();
    bus.spart_tx_data = 8'h3C;
    tick();
    bus.spart_tx_data = 8'hC3;
    tick();
    bus.spart_trmt = 1'b0;
    repeat (16) tick();
    chk("mid_busy", tx_busy, 1'b1);
    chk("mid_empty", tx_empty, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_txd", TxD, 1'b1);
    chk("mid_rst_empty", tx_empty, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    chk("mid_rst_full", bus.spart_tx_full, 1'b0);
    rst = 1'b0;
    wave_q.delete();
    rec = 1'b1;
    repeat (100) tick();
    rec = 1'b0;
    exp_q.delete();
    check_line("rst_mid", -1);
    chk("mid_after_empty", tx_empty, 1'b1);

    // 6. Pointer wrap: 9 bytes in bursts of 3
    for (int b = 0; b < 3; b++) begin
      wave_q.delete();
      exp_q.delete();
      rec = 1'b1;
      for (int j = 0; j < 3; j++) begin
        bus.spart_trmt = 1'b1;
        bus.spart_tx_data = 8'(8'h10 + 3 * b + j);
        exp_q.push_back(8'(8'h10 + 3 * b + j));
        tick();
      end
      bus.spart_trmt = 1'b0;
      repeat (130) tick();
      rec = 1'b0;
      check_line($sformatf("wrap_b%0d", b), 2);
    end
    chk("wrap_empty", tx_empty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_tx.md
# spart_tx

Transmit half of the SPART serial port. It accepts bytes from the MMU's SPART write path (`spart_tx_data`/`spart_trmt`), buffers them in a small FIFO, and serializes each one onto `TxD` as an 8N1 UART frame. It drives `spart_tx_full`, which the MMU samples before issuing a write.

## Interface
- `FIFO_DEPTH`, default 4: byte entries buffered; power of two, ≥2.
- `BAUD_DIV`, default 868: clock cycles per serial bit (100 MHz / 115200); ≥2.

- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `spart_trmt`  in  1  write strobe from the MMU; one byte per asserted cycle.
- `spart_tx_data`  in  8  byte to send; sampled when `spart_trmt`=1.
- `spart_tx_full`  out  1  FIFO holds `FIFO_DEPTH` bytes; writes are ignored while it is high.
- `tx_empty`  out  1  FIFO empty and shifter idle (line quiet).
- `tx_busy`  out  1  a frame is on the line (state ≠ IDLE).
- `TxD`  out  1  serial line; idle-high.

## Operation
- **Push:** on a clock edge with `spart_trmt`=1 and `spart_tx_full`=0, write `spart_tx_data` at the write pointer and increment the count. With `spart_tx_full`=1 the byte is dropped silently; pointer and count do not change.
- **`spart_tx_full`:** combinational from the registered count (count == `FIFO_DEPTH`), so it reflects the state at the start of the cycle.
- **Pop:** happens in IDLE, or on the last cycle of STOP, when count > 0. The head byte loads into the shift register, the read pointer advances, and the count decrements.
- **Simultaneous push and pop:**
  - The count is unchanged.
  - If the FIFO is full, the push is still rejected in that cycle, because `spart_tx_full` was high.
- **Pointers:** wrap modulo `FIFO_DEPTH`. The count is log2(`FIFO_DEPTH`)+1 bits wide.
- **State machine:**
  - IDLE: `TxD`=1. If count > 0, pop and go to START.
  - START: `TxD`=0 for `BAUD_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `TxD` = shift[0] for `BAUD_DIV` cycles per bit, shifting right, LSB first. After bit 7, go to STOP.
  - STOP: `TxD`=1 for `BAUD_DIV` cycles. At the end, pop and go to START if count > 0; otherwise go to IDLE.
- **Baud counter:**
  - Loads `BAUD_DIV`-1 on entry to each bit and counts down.
  - The bit ends on the cycle the counter reads 0.
  - The counter is held at 0 in IDLE.
- **Outputs:** `tx_busy` = (state ≠ IDLE). `tx_empty` = (count == 0) && (state == IDLE).
- **Reset values:** state IDLE, `TxD`=1, pointers and count 0, `spart_tx_full`=0, `tx_empty`=1, `tx_busy`=0, shift register 0.
- **Reset mid-frame:** the frame is aborted, `TxD`=1 from the next cycle, and the FIFO is flushed. No partial byte is retransmitted.

## Timing
- **Latency from idle:** `spart_trmt` at edge N (FIFO empty, IDLE) writes at N. The pop occurs at N+1, and `TxD` falls right after edge N+1.
- **Frame length:** exactly 10 × `BAUD_DIV` cycles.
- **Back-to-back bytes:** no idle cycles between a stop bit and the next start bit.
- **`spart_tx_full` release:** falls the cycle after the pop that frees an entry.
- **Register placement:** `TxD` is driven from a flop, so no combinational path runs from inputs to `TxD`.

## Structure
- Package `spart_pkg`:
  - state enum (IDLE, START, DATA, STOP);
  - `DATA_BITS`=8;
  - `FRAME_BITS`=10;
  - `IDLE_LEVEL`=1'b1.
  - The future `spart_rx` shares this package.
- Sub-module `spart_fifo`: synchronous FIFO (depth/width parameters, push/pop/full/empty/count). The transmitter instantiates it; `spart_rx` reuses it.
- Top level: the FSM, baud counter, bit index (3 bits) and shift register.

## Test plan
The bench uses `BAUD_DIV`=4 and `FIFO_DEPTH`=4.
1. **Reset:** hold `rst` for 5 cycles → `TxD`=1, `tx_empty`=1, `spart_tx_full`=0, `tx_busy`=0 throughout.
2. **Single byte:** one `spart_trmt` with 8'hA5 → `TxD` falls 2 cycles later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. Total 40 cycles low-to-idle; `tx_empty`=1 afterwards.
3. **Full and overflow:** six consecutive writes 8'h01..8'h06 → `spart_tx_full` asserts, and the sixth byte is dropped. The line carries bytes 01..05, contiguous, in order, with no gap between frames.
4. **Simultaneous push/pop at full:** FIFO full, and `spart_trmt` coincides with the STOP-end pop → the byte is rejected, the count goes from 4 to 3, and `spart_tx_full` deasserts the next cycle.
5. **Reset mid-frame:** assert `rst` during DATA bit 3 of 8'hFF with 2 bytes queued → `TxD`=1 next cycle, FIFO empty, and no further frames appear.
6. **Pointer wrap:** push and drain 9 bytes (8'h10..8'h18) in bursts of 3 → every byte is received in order, confirming pointer wrap-around.
